// File: rtl/otter_exec_ctrl.sv
// Multi-cycle control unit for the OTTER RV32I core.
// Sequences INIT/FETCH/EXEC/WRITEBACK/INTERRUPT and decodes IR into datapath controls.
module otter_exec_ctrl #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IR,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    input  logic        INTR,
    input  logic        MIE,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_SRCA,
    output logic [1:0]  ALU_SRCB,
    output logic [1:0]  RF_WR_SEL,
    output logic [2:0]  PC_SOURCE,
    output logic        PC_WRITE,
    output logic        REG_WRITE,
    output logic        MEM_RDEN1,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic        INT_TAKEN,
    output logic        ILLEGAL
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic [2:0] HOLD_LAST = 3'(RESET_PC_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] hold_q, hold_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       irq;
    logic       br_taken;
    logic       is_r, is_imm, is_lui, is_auipc, is_jal;
    logic       is_jalr, is_br, is_st, is_ld;
    logic       unused_ir;

    assign opcode    = IR[6:0];
    assign funct3    = IR[14:12];
    assign irq       = INTR & MIE;
    assign unused_ir = ^{IR[31], IR[29:15], IR[11:7]};

    assign is_r     = (opcode == OP_RTYPE);
    assign is_imm   = (opcode == OP_IMM);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_br    = (opcode == OP_BRANCH);
    assign is_st    = (opcode == OP_STORE);
    assign is_ld    = (opcode == OP_LOAD);

    // 010/011 are not branch encodings and fall through to not-taken.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = BR_EQ;
            3'b001:  br_taken = ~BR_EQ;
            3'b100:  br_taken = BR_LT;
            3'b101:  br_taken = ~BR_LT;
            3'b110:  br_taken = BR_LTU;
            3'b111:  br_taken = ~BR_LTU;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_INIT;
            hold_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        ALU_FUN   = 4'b0000;
        ALU_SRCA  = 1'b0;
        ALU_SRCB  = 2'd0;
        RF_WR_SEL = 2'd0;
        PC_SOURCE = 3'd0;
        PC_WRITE  = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        INT_TAKEN = 1'b0;
        ILLEGAL   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_FETCH;
                    hold_d  = 3'd0;
                end else begin
                    hold_d  = hold_q + 3'd1;
                end
            end

            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_d   = ST_EXEC;
            end

            ST_EXEC: begin
                state_d  = irq ? ST_INTR : ST_FETCH;
                PC_WRITE = 1'b1;
                unique case (1'b1)
                    is_r: begin
                        ALU_FUN   = {IR[30], funct3};
                        RF_WR_SEL = 2'd3;
                        REG_WRITE = 1'b1;
                    end
                    is_imm: begin
                        // Only the shift-right encoding uses IR[30] as ALU_FUN[3].
                        ALU_FUN   = {(funct3 == 3'b101) ? IR[30] : 1'b0, funct3};
                        ALU_SRCB  = 2'd1;
                        RF_WR_SEL = 2'd3;
                        REG_WRITE = 1'b1;
                    end
                    is_lui: begin
                        ALU_FUN   = 4'b1001;
                        ALU_SRCA  = 1'b1;
                        RF_WR_SEL = 2'd3;
                        REG_WRITE = 1'b1;
                    end
                    is_auipc: begin
                        ALU_SRCA  = 1'b1;
                        ALU_SRCB  = 2'd3;
                        RF_WR_SEL = 2'd3;
                        REG_WRITE = 1'b1;
                    end
                    is_jal: begin
                        REG_WRITE = 1'b1;
                        PC_SOURCE = 3'd3;
                    end
                    is_jalr: begin
                        REG_WRITE = 1'b1;
                        PC_SOURCE = 3'd1;
                    end
                    is_br: begin
                        PC_SOURCE = br_taken ? 3'd2 : 3'd0;
                    end
                    is_st: begin
                        ALU_SRCB = 2'd2;
                        MEM_WE2  = 1'b1;
                    end
                    is_ld: begin
                        ALU_SRCB  = 2'd1;
                        MEM_RDEN2 = 1'b1;
                        PC_WRITE  = 1'b0;
                        state_d   = ST_WB;
                    end
                    default: begin
                        ILLEGAL = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                // Keep the load address on the bus while data returns.
                ALU_SRCB  = 2'd1;
                RF_WR_SEL = 2'd2;
                REG_WRITE = 1'b1;
                PC_WRITE  = 1'b1;
                state_d   = irq ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                PC_WRITE  = 1'b1;
                PC_SOURCE = 3'd4;
                INT_TAKEN = 1'b1;
                state_d   = ST_FETCH;
            end

            default: begin
                state_d = ST_INIT;
                hold_d  = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_exec_ctrl.sv
// Scoreboard bench for otter_exec_ctrl: driver queues per-cycle expectations,
// monitor pops and compares on each falling edge.
module tb_otter_exec_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IR;
    logic        BR_EQ, BR_LT, BR_LTU, INTR, MIE;
    logic [3:0]  ALU_FUN;
    logic        ALU_SRCA;
    logic [1:0]  ALU_SRCB, RF_WR_SEL;
    logic [2:0]  PC_SOURCE;
    logic        PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2;
    logic        MEM_WE2, INT_TAKEN, ILLEGAL;

    otter_exec_ctrl #(.RESET_PC_HOLD(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .IR(IR),
        .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
        .INTR(INTR), .MIE(MIE),
        .ALU_FUN(ALU_FUN), .ALU_SRCA(ALU_SRCA), .ALU_SRCB(ALU_SRCB),
        .RF_WR_SEL(RF_WR_SEL), .PC_SOURCE(PC_SOURCE),
        .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
        .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
        .INT_TAKEN(INT_TAKEN), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // strobe field order: {pc_write, reg_write, rden1, rden2, we2, int_taken, illegal}
    localparam logic [6:0] S_PW = 7'b1000000;
    localparam logic [6:0] S_RW = 7'b0100000;
    localparam logic [6:0] S_R1 = 7'b0010000;
    localparam logic [6:0] S_R2 = 7'b0001000;
    localparam logic [6:0] S_WE = 7'b0000100;
    localparam logic [6:0] S_IT = 7'b0000010;
    localparam logic [6:0] S_IL = 7'b0000001;

    function automatic logic [18:0] mk(input logic [3:0] af, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic [2:0] ps, input logic [6:0] st);
        return {af, sa, sb, rs, ps, st};
    endfunction

    typedef struct {
        string       nm;
        logic [18:0] v;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [18:0] obs;
    int          n_run  = 0;
    int          n_fail = 0;
    event        sample_now;

    assign obs = {ALU_FUN, ALU_SRCA, ALU_SRCB, RF_WR_SEL, PC_SOURCE,
                  PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
                  INT_TAKEN, ILLEGAL};

    always @(negedge CLK or sample_now) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            n_run++;
            if (obs !== cur.v) begin
                n_fail++;
                $display("FAIL %s: got %05h expected %05h", cur.nm, obs, cur.v);
            end
        end
    end

    task automatic push(input string nm, input logic [18:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic [18:0] v);
        push(nm, v);
        @(posedge CLK);
        #1;
    endtask

    logic [18:0] Z, FE, LD_EX, LD_WB, IRQ;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Z     = '0;
        FE    = mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd0, S_R1);
        LD_EX = mk(4'd0, 1'b0, 2'd1, 2'd0, 3'd0, S_R2);
        LD_WB = mk(4'd0, 1'b0, 2'd1, 2'd2, 3'd0, S_PW | S_RW);
        IRQ   = mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd4, S_PW | S_IT);

        RST_N = 1'b0;
        IR    = 32'h0;
        {BR_EQ, BR_LT, BR_LTU, INTR, MIE} = '0;
        @(posedge CLK);
        #1;
        cyc("rst0", Z);
        cyc("rst1", Z);
        RST_N = 1'b1;
        cyc("init0", Z);
        cyc("init1", Z);

        IR = 32'h40535313;
        cyc("fetch", FE);
        cyc("srai", mk(4'b1101, 1'b0, 2'd1, 2'd3, 3'd0, S_PW | S_RW));
        IR = 32'h40050513;
        cyc("fetch", FE);
        cyc("addi_b30", mk(4'b0000, 1'b0, 2'd1, 2'd3, 3'd0, S_PW | S_RW));
        IR = 32'h40B50533;
        cyc("fetch", FE);
        cyc("sub", mk(4'b1000, 1'b0, 2'd0, 2'd3, 3'd0, S_PW | S_RW));
        IR = 32'h123450B7;
        cyc("fetch", FE);
        cyc("lui", mk(4'b1001, 1'b1, 2'd0, 2'd3, 3'd0, S_PW | S_RW));
        IR = 32'h00001517;
        cyc("fetch", FE);
        cyc("auipc", mk(4'b0000, 1'b1, 2'd3, 2'd3, 3'd0, S_PW | S_RW));
        IR = 32'h0080006F;
        cyc("fetch", FE);
        cyc("jal", mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd3, S_PW | S_RW));
        IR = 32'h00008067;
        cyc("fetch", FE);
        cyc("jalr", mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd1, S_PW | S_RW));

        IR = 32'h0000A083;
        cyc("fetch", FE);
        cyc("lw_exec", LD_EX);
        cyc("lw_wb", LD_WB);

        IR = 32'h00B50463;
        BR_EQ = 1'b1;
        cyc("fetch", FE);
        cyc("beq_t", mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd2, S_PW));
        BR_EQ = 1'b0;
        cyc("fetch", FE);
        cyc("beq_nt", mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd0, S_PW));
        IR = 32'h00B54463;
        BR_LT = 1'b1;
        cyc("fetch", FE);
        cyc("blt_t", mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd2, S_PW));
        IR = 32'h00B52463;
        {BR_EQ, BR_LT, BR_LTU} = 3'b111;
        cyc("fetch", FE);
        cyc("br010_nt", mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd0, S_PW));
        {BR_EQ, BR_LT, BR_LTU} = 3'b000;

        IR = 32'h0000A083;
        cyc("fetch", FE);
        INTR = 1'b1;
        MIE  = 1'b1;
        cyc("irq_ld_exec", LD_EX);
        cyc("irq_ld_wb", LD_WB);
        cyc("irq_state", IRQ);
        cyc("irq_refetch", FE);
        INTR = 1'b0;
        cyc("ld2_exec", LD_EX);
        cyc("ld2_wb", LD_WB);
        INTR = 1'b1;
        MIE  = 1'b0;
        cyc("mie0_fetch", FE);
        cyc("mie0_exec", LD_EX);
        cyc("mie0_wb", LD_WB);
        MIE = 1'b1;
        cyc("fetch_irq_hi", FE);
        INTR = 1'b0;
        cyc("defer_exec", LD_EX);
        cyc("defer_wb", LD_WB);
        MIE = 1'b0;

        IR = 32'h00A12023;
        cyc("fetch", FE);
        push("sw_exec", mk(4'd0, 1'b0, 2'd2, 2'd0, 3'd0, S_PW | S_WE));
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        push("rst_async", Z);
        ->sample_now;
        @(posedge CLK);
        #1;
        cyc("rst_hold", Z);
        RST_N = 1'b1;
        cyc("init0b", Z);
        cyc("init1b", Z);

        IR = 32'h0000007F;
        cyc("fetch", FE);
        cyc("illegal", mk(4'd0, 1'b0, 2'd0, 2'd0, 3'd0, S_PW | S_IL));
        IR = 32'h40B50533;
        cyc("post_ill", FE);

        repeat (2) @(negedge CLK);
        #1;
        n_run++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
